// File: rtl/alu_trace_capture.sv
// Trigger-based trace buffer for a datapath value: records samples into a circular
// buffer around a masked-compare trigger, then plays the window back oldest-first.
module alu_trace_capture #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_vld_i,
  input  logic [DATA_W-1:0] trig_val_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic              arm_i,
  input  logic              rd_req_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_vld_o,
  output logic [1:0]        state_o,
  output logic              triggered_o,
  output logic [CW-1:0]     count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_post_cnt;
  logic [CW-1:0]     r_count;
  logic              r_trig;
  logic              r_rd_vld;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_buf [DEPTH];

  logic              w_hit;
  logic              w_capture;
  logic [AW-1:0]     w_wr_nxt;
  logic [CW-1:0]     w_fill_nxt;
  logic [AW-1:0]     w_oldest;

  always_comb begin
    w_hit      = sample_vld_i && (((sample_i ^ trig_val_i) & trig_mask_i) == '0);
    w_capture  = sample_vld_i && (r_state == S_ARMED || r_state == S_POST);
    w_wr_nxt   = r_wr_ptr + 1'b1;
    w_fill_nxt = (r_count == CW'(DEPTH)) ? r_count : r_count + 1'b1;
    // Oldest entry as seen after this cycle's write; a full buffer gives wr_nxt itself.
    w_oldest   = w_wr_nxt - w_fill_nxt[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (w_capture) r_buf[r_wr_ptr] <= sample_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_post_cnt <= '0;
      r_count    <= '0;
      r_trig     <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_vld <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (arm_i) begin
            r_state  <= S_ARMED;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_trig   <= 1'b0;
          end else if (r_state == S_DONE && rd_req_i && r_count != '0) begin
            r_rd_data <= r_buf[r_rd_ptr];
            r_rd_vld  <= 1'b1;
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_count   <= r_count - 1'b1;
            if (r_count == CW'(1)) r_state <= S_IDLE;
          end
        end
        S_ARMED: begin
          if (sample_vld_i) begin
            r_wr_ptr <= w_wr_nxt;
            r_count  <= w_fill_nxt;
            if (w_hit) begin
              r_trig <= 1'b1;
              if (POST_TRIG == 0) begin
                r_state  <= S_DONE;
                r_rd_ptr <= w_oldest;
              end else begin
                r_state    <= S_POST;
                r_post_cnt <= AW'(POST_TRIG);
              end
            end
          end
        end
        S_POST: begin
          if (sample_vld_i) begin
            r_wr_ptr   <= w_wr_nxt;
            r_count    <= w_fill_nxt;
            r_post_cnt <= r_post_cnt - 1'b1;
            if (r_post_cnt == AW'(1)) begin
              r_state  <= S_DONE;
              r_rd_ptr <= w_oldest;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_data_o   = r_rd_data;
  assign rd_vld_o    = r_rd_vld;
  assign state_o     = r_state;
  assign triggered_o = r_trig;
  assign count_o     = r_count;

endmodule

// File: tb/tb_alu_trace_capture.sv
// Directed bench for alu_trace_capture: DEPTH=8/POST_TRIG=2 main instance plus a
// POST_TRIG=0 instance sharing the same inputs.
module tb_alu_trace_capture;

  logic        clk;
  logic        reset;
  logic [31:0] sample_i, trig_val_i, trig_mask_i;
  logic        sample_vld_i, arm_i, rd_req_i;

  logic [31:0] rd_data0, rd_data1;
  logic        rd_vld0, rd_vld1, trg0, trg1;
  logic [1:0]  st0, st1;
  logic [3:0]  cnt0, cnt1;

  int n_checks = 0;
  int n_errors = 0;

  alu_trace_capture #(.DATA_W(32), .DEPTH(8), .POST_TRIG(2)) u_dut (
    .clk(clk), .reset(reset), .sample_i(sample_i), .sample_vld_i(sample_vld_i),
    .trig_val_i(trig_val_i), .trig_mask_i(trig_mask_i), .arm_i(arm_i),
    .rd_req_i(rd_req_i), .rd_data_o(rd_data0), .rd_vld_o(rd_vld0),
    .state_o(st0), .triggered_o(trg0), .count_o(cnt0)
  );

  alu_trace_capture #(.DATA_W(32), .DEPTH(8), .POST_TRIG(0)) u_dut0 (
    .clk(clk), .reset(reset), .sample_i(sample_i), .sample_vld_i(sample_vld_i),
    .trig_val_i(trig_val_i), .trig_mask_i(trig_mask_i), .arm_i(arm_i),
    .rd_req_i(rd_req_i), .rd_data_o(rd_data1), .rd_vld_o(rd_vld1),
    .state_o(st1), .triggered_o(trg1), .count_o(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        arm;
    logic        vld;
    logic [31:0] smp;
    logic        rd;
    logic [31:0] tmask;
    logic [1:0]  st;
    logic [3:0]  cnt;
    logic        trg;
    logic        rv;
    logic [31:0] rdat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic a, input logic v, input int s, input logic r,
                              input logic [31:0] m, input int st, input int c,
                              input logic t, input logic rv, input int d);
    vec_t x;
    x.arm = a; x.vld = v; x.smp = s; x.rd = r; x.tmask = m;
    x.st = st[1:0]; x.cnt = c[3:0]; x.trg = t; x.rv = rv; x.rdat = d;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic a, input logic v, input int s, input logic r);
    arm_i = a; sample_vld_i = v; sample_i = s; rd_req_i = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; sample_i = '0; sample_vld_i = 1'b0; trig_val_i = 32'd3;
    trig_mask_i = '1; arm_i = 1'b0; rd_req_i = 1'b0;
    #12;
    check("rst_state", st0, 0);
    check("rst_count", cnt0, 0);
    check("rst_trig", trg0, 0);
    check("rst_rvld", rd_vld0, 0);
    check("rst_rdata", rd_data0, 0);
    reset = 1'b1;

    // Basic capture (trig_val=3) then masked trigger with valid gaps.
    tbl.push_back(mk(1, 0, 0, 0, '1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, '1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2, 0, '1, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, '1, 2, 3, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4, 0, '1, 2, 4, 1, 0, 0));
    tbl.push_back(mk(0, 1, 5, 0, '1, 3, 5, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, '1, 3, 4, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, '1, 3, 3, 1, 1, 2));
    tbl.push_back(mk(0, 0, 0, 1, '1, 3, 2, 1, 1, 3));
    tbl.push_back(mk(0, 0, 0, 1, '1, 3, 1, 1, 1, 4));
    tbl.push_back(mk(0, 0, 0, 1, '1, 0, 0, 1, 1, 5));
    tbl.push_back(mk(0, 0, 0, 1, '1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, '0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 7, 0, '0, 2, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, '0, 2, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, '0, 2, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, '0, 2, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8, 0, '0, 2, 2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 9, 0, '0, 3, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, '0, 3, 2, 1, 1, 7));
    tbl.push_back(mk(0, 0, 0, 1, '0, 3, 1, 1, 1, 8));
    tbl.push_back(mk(0, 0, 0, 1, '0, 0, 0, 1, 1, 9));

    foreach (tbl[i]) begin
      trig_mask_i = tbl[i].tmask;
      step(tbl[i].arm, tbl[i].vld, int'(tbl[i].smp), tbl[i].rd);
      check($sformatf("v%0d_state", i), st0, tbl[i].st);
      check($sformatf("v%0d_count", i), cnt0, tbl[i].cnt);
      check($sformatf("v%0d_trig", i), trg0, tbl[i].trg);
      check($sformatf("v%0d_rvld", i), rd_vld0, tbl[i].rv);
      if (tbl[i].rv) check($sformatf("v%0d_rdata", i), rd_data0, tbl[i].rdat);
    end

    // Wrap: 20 samples into 8 entries, window is 13..20.
    trig_mask_i = '1; trig_val_i = 32'd18;
    step(1, 0, 0, 0);
    for (int s = 1; s <= 20; s++) begin
      step(0, 1, s, 0);
      if (s == 18) check("wrap_post", st0, 2);
    end
    check("wrap_done", st0, 3);
    check("wrap_count", cnt0, 8);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, 1);
      check($sformatf("wrap_rvld%0d", k), rd_vld0, 1);
      check($sformatf("wrap_rd%0d", k), rd_data0, 13 + k);
    end
    check("wrap_idle", st0, 0);

    // Abort during readout: arm beats rd_req.
    trig_val_i = 32'd3;
    step(1, 0, 0, 0);
    for (int s = 1; s <= 5; s++) step(0, 1, s, 0);
    check("abort_done", st0, 3);
    step(0, 0, 0, 1);
    check("abort_rd1", rd_data0, 1);
    step(1, 0, 0, 1);
    check("abort_state", st0, 1);
    check("abort_rvld", rd_vld0, 0);
    check("abort_count", cnt0, 0);
    check("abort_trig", trg0, 0);

    // Asynchronous reset in the middle of POST.
    step(0, 1, 3, 0);
    check("mid_post", st0, 2);
    arm_i = 1'b0; sample_vld_i = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_state", st0, 0);
    check("arst_count", cnt0, 0);
    check("arst_trig", trg0, 0);
    check("arst_rvld", rd_vld0, 0);
    check("arst_rdata", rd_data0, 0);
    #3 reset = 1'b1;
    step(0, 0, 0, 1);
    check("arst_rd_ign", rd_vld0, 0);
    check("arst_rd_idle", st0, 0);

    // Zero post-trigger instance.
    trig_val_i = 32'd42;
    step(1, 0, 0, 0);
    check("zp_armed", st1, 1);
    step(0, 1, 42, 0);
    check("zp_done", st1, 3);
    check("zp_count", cnt1, 1);
    check("zp_trig", trg1, 1);
    step(0, 0, 0, 1);
    check("zp_rvld", rd_vld1, 1);
    check("zp_rdata", rd_data1, 42);
    check("zp_idle", st1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
